register_write_scheduler: RTL and testbench

REGISTER_WRITE_SCHEDULER -- requirements
Module: register_write_scheduler

---
 rtl/fpga9685_pkg.sv | 26 ++
 rtl/register_write_scheduler.sv | 125 ++++++++++++
 tb/tb_register_write_scheduler.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpga9685_pkg.sv
// Shared constants and types for the PCA9685-style register front end.
// Address map, MODE1 defaults and the write scheduler state encoding.
package fpga9685_pkg;

    localparam logic [7:0] MODE1         = 8'h00;
    localparam logic [7:0] LED0_ON_L     = 8'h06;
    localparam logic [7:0] LED15_OFF_H   = 8'h45;
    localparam logic [7:0] ALL_LED_ON_L  = 8'hFA;
    localparam logic [7:0] ALL_LED_OFF_H = 8'hFD;
    localparam logic [7:0] PRE_SCALE     = 8'hFE;

    localparam int unsigned SLEEP_BIT    = 4;
    localparam logic [7:0]  MODE1_RESET  = 8'h11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_BCAST = 2'd2
    } sched_state_t;

    // Per-channel address of an ALL_LED_* register: each LED owns four bytes.
    function automatic logic [7:0] bcast_addr(input logic [3:0] ch, input logic [1:0] off);
        bcast_addr = LED0_ON_L + {2'b00, ch, 2'b00} + {6'b000000, off};
    endfunction

endpackage

// File: rtl/register_write_scheduler.sv
// Turns I2C register writes into register-file strobes, expanding ALL_LED_*
// writes into per-channel writes and gating PRE_SCALE on the MODE1 SLEEP bit.
module register_write_scheduler
    import fpga9685_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] req_id_i,
    input  logic [7:0] req_value_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    output logic [7:0] write_register_id_o,
    output logic [7:0] write_register_value_o,
    output logic       write_enable_o,
    output logic       sleep_o,
    output logic       dropped_o,
    output logic       busy_o
);

    sched_state_t state_q, state_d;
    logic [3:0]   ch_q, ch_d;
    logic [7:0]   bid_q, bid_d;
    logic [7:0]   id_q, id_d;
    logic [7:0]   val_q, val_d;
    logic         we_q, we_d;
    logic         drop_q, drop_d;
    logic [7:0]   mode1_q, mode1_d;

    logic         fwd_s;
    logic         bcast_s;

    always_comb begin
        fwd_s   = (req_id_i <= LED15_OFF_H) || (req_id_i == 8'hFF) ||
                  ((req_id_i == PRE_SCALE) && mode1_q[SLEEP_BIT]);
        bcast_s = (req_id_i >= ALL_LED_ON_L) && (req_id_i <= ALL_LED_OFF_H);
    end

    // Channel 0 is emitted on acceptance; ch_q==0 inside BCAST means the
    // counter wrapped after channel 15 and the original id goes out last.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        bid_d   = bid_q;
        id_d    = id_q;
        val_d   = val_q;
        we_d    = 1'b0;
        drop_d  = 1'b0;
        mode1_d = mode1_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (fwd_s) begin
                        state_d = ST_EMIT;
                        we_d    = 1'b1;
                        id_d    = req_id_i;
                        val_d   = req_value_i;
                        if (req_id_i == MODE1) begin
                            mode1_d = req_value_i;
                        end else begin
                            mode1_d = mode1_q;
                        end
                    end else if (bcast_s) begin
                        state_d = ST_BCAST;
                        we_d    = 1'b1;
                        id_d    = bcast_addr(4'd0, req_id_i[1:0] - 2'd2);
                        val_d   = req_value_i;
                        bid_d   = req_id_i;
                        ch_d    = 4'd1;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BCAST: begin
                we_d = 1'b1;
                if (ch_q == 4'd0) begin
                    id_d    = bid_q;
                    state_d = ST_EMIT;
                end else begin
                    id_d = bcast_addr(ch_q, bid_q[1:0] - 2'd2);
                    ch_d = ch_q + 4'd1;
                end
            end
            ST_EMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ch_q    <= 4'd0;
            bid_q   <= 8'h00;
            id_q    <= 8'h00;
            val_q   <= 8'h00;
            we_q    <= 1'b0;
            drop_q  <= 1'b0;
            mode1_q <= MODE1_RESET;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            bid_q   <= bid_d;
            id_q    <= id_d;
            val_q   <= val_d;
            we_q    <= we_d;
            drop_q  <= drop_d;
            mode1_q <= mode1_d;
        end
    end

    assign req_ready_o            = (state_q == ST_IDLE);
    assign busy_o                 = (state_q != ST_IDLE);
    assign write_register_id_o    = id_q;
    assign write_register_value_o = val_q;
    assign write_enable_o         = we_q;
    assign dropped_o              = drop_q;
    assign sleep_o                = mode1_q[SLEEP_BIT];

endmodule

// File: tb/tb_register_write_scheduler.sv
// Scoreboard bench for register_write_scheduler: stimulus pushes expected
// writes/drops, a negedge monitor pops and compares what the DUT emits.
module tb_register_write_scheduler;

    logic       clk;
    logic       rst;
    logic [7:0] req_id;
    logic [7:0] req_val;
    logic       req_valid;
    logic       req_ready_o;
    logic [7:0] write_register_id_o;
    logic [7:0] write_register_value_o;
    logic       write_enable_o;
    logic       sleep_o;
    logic       dropped_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    int          exp_drops = 0;
    logic        exp_sleep = 1'b1;
    logic        rst_at_edge = 1'b1;
    logic [15:0] last_out = 16'h0000;

    register_write_scheduler dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .req_id_i               (req_id),
        .req_value_i            (req_val),
        .req_valid_i            (req_valid),
        .req_ready_o            (req_ready_o),
        .write_register_id_o    (write_register_id_o),
        .write_register_value_o (write_register_value_o),
        .write_enable_o         (write_enable_o),
        .sleep_o                (sleep_o),
        .dropped_o              (dropped_o),
        .busy_o                 (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rst_at_edge <= rst;

    // Monitor: pops expected writes/drops, checks id/value hold between strobes.
    always @(negedge clk) begin
        logic [15:0] cur;
        logic [15:0] exp;
        cur = {write_register_id_o, write_register_value_o};
        if (write_enable_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got id/val %h, none expected", cur);
            end else begin
                exp = exp_q.pop_front();
                if (cur !== exp) begin
                    errors++;
                    $display("FAIL write: got id/val %h, expected %h", cur, exp);
                end
            end
        end else begin
            checks++;
            exp = rst_at_edge ? 16'h0000 : last_out;
            if (cur !== exp) begin
                errors++;
                $display("FAIL hold: got id/val %h, expected %h", cur, exp);
            end
        end
        last_out = cur;
        if (dropped_o === 1'b1) begin
            checks++;
            if (exp_drops == 0) begin
                errors++;
                $display("FAIL unexpected_drop: got dropped=1, expected 0");
            end else begin
                exp_drops--;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic model_push(input logic [7:0] id, input logic [7:0] val);
        logic [7:0] addr;
        if (id <= 8'h45 || id == 8'hFF || (id == 8'hFE && exp_sleep)) begin
            exp_q.push_back({id, val});
            if (id == 8'h00) exp_sleep = val[4];
        end else if (id >= 8'hFA && id <= 8'hFD) begin
            for (int k = 0; k < 16; k++) begin
                addr = 8'h06 + 8'(4 * k) + (id - 8'hFA);
                exp_q.push_back({addr, val});
            end
            exp_q.push_back({id, val});
        end else begin
            exp_drops++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_sleep = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [7:0] id, input logic [7:0] val, input bit push, output int waits);
        bit active;
        active = (id <= 8'h45) || (id == 8'hFF) || (id == 8'hFE && exp_sleep) ||
                 (id >= 8'hFA && id <= 8'hFD);
        if (push) model_push(id, val);
        req_id = id;
        req_val = val;
        req_valid = 1'b1;
        waits = 0;
        while (req_ready_o !== 1'b1 && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (req_ready_o !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: id %h not accepted after %0d cycles", id, waits);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            check("busy_after_accept", {15'd0, busy_o}, {15'd0, active});
            check("dropped_after_accept", {15'd0, dropped_o}, {15'd0, !active});
        end
    endtask

    initial begin
        int w;
        rst = 1'b1;
        req_id = 8'h00;
        req_val = 8'h00;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_ready", {15'd0, req_ready_o}, 16'd1);
        check("rst_busy", {15'd0, busy_o}, 16'd0);
        check("rst_we", {15'd0, write_enable_o}, 16'd0);
        check("rst_sleep", {15'd0, sleep_o}, 16'd1);
        check("rst_idval", {write_register_id_o, write_register_value_o}, 16'h0000);
        rst = 1'b0;

        // Simple forwarded write: accepted at once, ready again the cycle after the strobe.
        send(8'h06, 8'h5A, 1'b1, w);
        check("single_wait", 16'(w), 16'd0);
        check("single_ready_low", {15'd0, req_ready_o}, 16'd0);
        @(negedge clk);
        check("single_ready_back", {15'd0, req_ready_o}, 16'd1);

        // Broadcast, with a second request held until IDLE returns.
        send(8'hFC, 8'h10, 1'b1, w);
        send(8'h06, 8'h33, 1'b1, w);
        check("held_req_wait", 16'(w), 16'd17);
        @(negedge clk);

        // PRE_SCALE gating by the sleep shadow.
        do_reset();
        send(8'hFE, 8'h79, 1'b1, w);
        send(8'h00, 8'h01, 1'b1, w);
        check("sleep_cleared", {15'd0, sleep_o}, 16'd0);
        @(negedge clk);
        send(8'hFE, 8'h03, 1'b1, w);
        check("sleep_still_0", {15'd0, sleep_o}, 16'd0);

        // Unmapped id is dropped.
        send(8'h80, 8'hFF, 1'b1, w);
        @(negedge clk);
        check("drop_idle", {15'd0, busy_o}, 16'd0);

        // Broadcast re-enabling sleep via MODE1 does not apply; FF forwards.
        send(8'hFF, 8'hA5, 1'b1, w);
        @(negedge clk);

        // Reset at broadcast pulse 5: only channels 0-4 written.
        do_reset();
        exp_q.push_back(16'h0622);
        exp_q.push_back(16'h0A22);
        exp_q.push_back(16'h0E22);
        exp_q.push_back(16'h1222);
        exp_q.push_back(16'h1622);
        send(8'hFA, 8'h22, 1'b0, w);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_sleep = 1'b1;
        check("abort_we", {15'd0, write_enable_o}, 16'd0);
        check("abort_ready", {15'd0, req_ready_o}, 16'd1);
        check("abort_sleep", {15'd0, sleep_o}, 16'd1);
        check("abort_busy", {15'd0, busy_o}, 16'd0);
        repeat (20) @(negedge clk);

        // Reset wins over a simultaneous request.
        req_id = 8'h06;
        req_val = 8'h77;
        req_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        check("rst_prio_busy", {15'd0, busy_o}, 16'd0);
        check("rst_prio_ready", {15'd0, req_ready_o}, 16'd1);
        repeat (3) @(negedge clk);
        check("rst_prio_idle", {15'd0, busy_o}, 16'd0);

        check("writes_pending", 16'(exp_q.size()), 16'd0);
        check("drops_pending", 16'(exp_drops), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
